// File: rtl/color_pkg.sv
// Shared class encodings and FSM state constants for the colour
// classification slice.
package color_pkg;

    typedef logic [1:0] color_cls_t;

    localparam color_cls_t CLS_NONE  = 2'd0;
    localparam color_cls_t CLS_RED   = 2'd1;
    localparam color_cls_t CLS_GREEN = 2'd2;
    localparam color_cls_t CLS_BLUE  = 2'd3;

    localparam logic [1:0] ST_ACCUM  = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

endpackage

// File: rtl/color_dominance.sv
// Divider-free colour decision on one set of averaged channel values:
// a channel wins only if it beats both others by the configured margin.
module color_dominance import color_pkg::*; #(
    parameter int DARK_TH      = 64,
    parameter int MARGIN_SHIFT = 2
) (
    input  logic [15:0] avg_r,
    input  logic [15:0] avg_g,
    input  logic [15:0] avg_b,
    output color_cls_t  cls
);

    logic [17:0] total;

    // 17-bit compare: other + other/2^MARGIN_SHIFT cannot overflow
    function automatic logic dominates(input logic [15:0] ch, input logic [15:0] other);
        logic [16:0] limit;
        limit = {1'b0, other} + {1'b0, (other >> MARGIN_SHIFT)};
        return {1'b0, ch} > limit;
    endfunction

    always_comb begin
        total = {2'b00, avg_r} + {2'b00, avg_g} + {2'b00, avg_b};
        cls   = CLS_NONE;
        if (total >= 18'(DARK_TH)) begin
            if (dominates(avg_r, avg_g) && dominates(avg_r, avg_b))
                cls = CLS_RED;
            else if (dominates(avg_g, avg_r) && dominates(avg_g, avg_b))
                cls = CLS_GREEN;
            else if (dominates(avg_b, avg_r) && dominates(avg_b, avg_g))
                cls = CLS_BLUE;
        end
    end

endmodule

// File: rtl/color_classifier.sv
// Averages RGB triples over a window, classifies each window, debounces the
// class over consecutive windows and counts confirmed coloured objects.
module color_classifier import color_pkg::*; #(
    parameter int AVG_LOG2     = 2,
    parameter int DARK_TH      = 64,
    parameter int MARGIN_SHIFT = 2,
    parameter int STABLE_N     = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [15:0]      red,
    input  logic [15:0]      green,
    input  logic [15:0]      blue,
    input  logic             clear_counts,
    output logic             class_valid,
    output color_cls_t       color_class,
    output color_cls_t       stable_class,
    output logic             count_pulse,
    output logic [CNT_W-1:0] cnt_red,
    output logic [CNT_W-1:0] cnt_green,
    output logic [CNT_W-1:0] cnt_blue,
    output logic             overrun
);

    // AVG_LOG2 must be at least 1 so the sample counter has a bit to hold
    localparam int ACC_W = 16 + AVG_LOG2;
    localparam int RUN_W = $clog2(STABLE_N + 1);
    localparam logic [AVG_LOG2-1:0] LAST_SMP = '1;
    localparam logic [RUN_W-1:0]    RUN_MAX  = RUN_W'(STABLE_N);
    localparam logic [RUN_W-1:0]    RUN_ONE  = RUN_W'(1);

    logic [1:0]          state;
    logic [ACC_W-1:0]    acc_r_p0, acc_g_p0, acc_b_p0;
    logic [AVG_LOG2-1:0] smp_cnt;
    logic [15:0]         avg_r_p1, avg_g_p1, avg_b_p1;
    color_cls_t          win_cls_p1;
    color_cls_t          candidate, nxt_cand;
    logic [RUN_W-1:0]    run_len, nxt_run;
    logic                confirm;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ---- CALC stage: truncating average and window decision ----
    assign avg_r_p1 = acc_r_p0[ACC_W-1:AVG_LOG2];
    assign avg_g_p1 = acc_g_p0[ACC_W-1:AVG_LOG2];
    assign avg_b_p1 = acc_b_p0[ACC_W-1:AVG_LOG2];

    color_dominance #(
        .DARK_TH      (DARK_TH),
        .MARGIN_SHIFT (MARGIN_SHIFT)
    ) u_dominance (
        .avg_r (avg_r_p1),
        .avg_g (avg_g_p1),
        .avg_b (avg_b_p1),
        .cls   (win_cls_p1)
    );

    // ---- UPDATE stage: run-length debounce ----
    always_comb begin
        nxt_cand = color_class;
        nxt_run  = RUN_ONE;
        if (color_class == candidate) begin
            nxt_cand = candidate;
            nxt_run  = (run_len >= RUN_MAX) ? RUN_MAX : run_len + RUN_ONE;
        end
        confirm = (state == ST_UPDATE) && (nxt_run == RUN_MAX) &&
                  (nxt_cand != stable_class);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_ACCUM;
            acc_r_p0     <= '0;
            acc_g_p0     <= '0;
            acc_b_p0     <= '0;
            smp_cnt      <= '0;
            run_len      <= '0;
            candidate    <= CLS_NONE;
            color_class  <= CLS_NONE;
            stable_class <= CLS_NONE;
            class_valid  <= 1'b0;
            count_pulse  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            class_valid <= (state == ST_CALC);
            overrun     <= sample_valid && (state != ST_ACCUM);
            count_pulse <= confirm && (nxt_cand != CLS_NONE);
            case (state)
                ST_ACCUM: begin
                    if (sample_valid) begin
                        acc_r_p0 <= acc_r_p0 + ACC_W'(red);
                        acc_g_p0 <= acc_g_p0 + ACC_W'(green);
                        acc_b_p0 <= acc_b_p0 + ACC_W'(blue);
                        smp_cnt  <= smp_cnt + AVG_LOG2'(1);
                        if (smp_cnt == LAST_SMP)
                            state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_r_p0    <= '0;
                    acc_g_p0    <= '0;
                    acc_b_p0    <= '0;
                    smp_cnt     <= '0;
                    color_class <= win_cls_p1;
                    state       <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    candidate <= nxt_cand;
                    run_len   <= nxt_run;
                    if (confirm)
                        stable_class <= nxt_cand;
                    state <= ST_ACCUM;
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

    // Clear beats a coincident increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_red   <= '0;
            cnt_green <= '0;
            cnt_blue  <= '0;
        end else if (clear_counts) begin
            cnt_red   <= '0;
            cnt_green <= '0;
            cnt_blue  <= '0;
        end else if (confirm) begin
            case (nxt_cand)
                CLS_RED:   cnt_red   <= sat_inc(cnt_red);
                CLS_GREEN: cnt_green <= sat_inc(cnt_green);
                CLS_BLUE:  cnt_blue  <= sat_inc(cnt_blue);
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_color_classifier.sv
// Randomised and directed bench for color_classifier against a window-level
// reference model (sums, class rules, history of recent window classes).
`timescale 1ns/1ps
module tb_color_classifier;

    localparam int AVG_LOG2     = 2;
    localparam int DARK_TH      = 64;
    localparam int MARGIN_SHIFT = 2;
    localparam int STABLE_N     = 3;
    localparam int CNT_W        = 2;
    localparam int NSMP         = 1 << AVG_LOG2;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sample_valid = 1'b0;
    logic [15:0]      red = '0, green = '0, blue = '0;
    logic             clear_counts = 1'b0;
    logic             class_valid;
    logic [1:0]       color_class, stable_class;
    logic             count_pulse;
    logic [CNT_W-1:0] cnt_red, cnt_green, cnt_blue;
    logic             overrun;

    color_classifier #(
        .AVG_LOG2(AVG_LOG2), .DARK_TH(DARK_TH), .MARGIN_SHIFT(MARGIN_SHIFT),
        .STABLE_N(STABLE_N), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .red(red), .green(green), .blue(blue), .clear_counts(clear_counts),
        .class_valid(class_valid), .color_class(color_class),
        .stable_class(stable_class), .count_pulse(count_pulse),
        .cnt_red(cnt_red), .cnt_green(cnt_green), .cnt_blue(cnt_blue),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int sum_r, sum_g, sum_b, n_smp;
    int hist[$];
    int exp_stable;
    int exp_cnt[4];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit dom(input int a, input int b);
        return a > b + (b / (1 << MARGIN_SHIFT));
    endfunction

    function automatic int classify(input int ar, input int ag, input int ab);
        if (ar + ag + ab < DARK_TH) return 0;
        if (dom(ar, ag) && dom(ar, ab)) return 1;
        if (dom(ag, ar) && dom(ag, ab)) return 2;
        if (dom(ab, ar) && dom(ab, ag)) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        sum_r = 0; sum_g = 0; sum_b = 0; n_smp = 0;
        hist.delete();
        exp_stable = 0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, ".cnt_red"},   int'(cnt_red),   exp_cnt[1]);
        chk({tag, ".cnt_green"}, int'(cnt_green), exp_cnt[2]);
        chk({tag, ".cnt_blue"},  int'(cnt_blue),  exp_cnt[3]);
    endtask

    // one accepted sample, preceded by a few idle cycles of junk input
    task automatic drive_sample(input int r, input int g, input int b);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(negedge clk);
            red = 16'($urandom); green = 16'($urandom); blue = 16'($urandom);
        end
        @(negedge clk);
        red = 16'(r); green = 16'(g); blue = 16'(b); sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        red = 16'($urandom); green = 16'($urandom); blue = 16'($urandom);
        sum_r += r; sum_g += g; sum_b += b; n_smp++;
    endtask

    // called right after the last sample of a window has been taken
    task automatic window_done(input bit inj, input bit clr);
        int  cls;
        bit  same, conf, pulse;
        cls = classify(sum_r >> AVG_LOG2, sum_g >> AVG_LOG2, sum_b >> AVG_LOG2);
        sum_r = 0; sum_g = 0; sum_b = 0; n_smp = 0;
        hist.push_back(cls);
        if (hist.size() > STABLE_N) void'(hist.pop_front());
        same = (hist.size() == STABLE_N);
        foreach (hist[i]) if (hist[i] != cls) same = 1'b0;
        conf  = same && (cls != exp_stable);
        pulse = conf && (cls != 0);
        if (conf) exp_stable = cls;
        if (pulse && exp_cnt[cls] < CNT_MAX) exp_cnt[cls]++;
        if (clr) for (int i = 0; i < 4; i++) exp_cnt[i] = 0;

        chk("calc.class_valid", int'(class_valid), 0);
        if (inj) begin
            red = 16'($urandom); green = 16'($urandom); blue = 16'($urandom);
            sample_valid = 1'b1;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        chk("upd.class_valid", int'(class_valid), 1);
        chk("upd.color_class", int'(color_class), cls);
        chk("upd.overrun",     int'(overrun), int'(inj));
        chk("upd.count_pulse", int'(count_pulse), 0);
        if (clr) clear_counts = 1'b1;
        @(negedge clk);
        clear_counts = 1'b0;
        chk("post.class_valid",  int'(class_valid), 0);
        chk("post.overrun",      int'(overrun), 0);
        chk("post.count_pulse",  int'(count_pulse), int'(pulse));
        chk("post.stable_class", int'(stable_class), exp_stable);
        check_counts("post");
    endtask

    task automatic send_window(input int r, input int g, input int b,
                               input bit inj, input bit clr);
        for (int i = 0; i < NSMP; i++) drive_sample(r, g, b);
        window_done(inj, clr);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".class_valid"},  int'(class_valid), 0);
        chk({tag, ".color_class"},  int'(color_class), 0);
        chk({tag, ".stable_class"}, int'(stable_class), 0);
        chk({tag, ".count_pulse"},  int'(count_pulse), 0);
        chk({tag, ".overrun"},      int'(overrun), 0);
        check_counts(tag);
    endtask

    task automatic random_triple(input int kind, output int r, output int g, output int b);
        int hi;
        hi = $urandom_range(2000, 60000);
        case (kind)
            1: begin r = hi; g = $urandom_range(0, hi / 2); b = $urandom_range(0, hi / 2); end
            2: begin g = hi; r = $urandom_range(0, hi / 2); b = $urandom_range(0, hi / 2); end
            3: begin b = hi; r = $urandom_range(0, hi / 2); g = $urandom_range(0, hi / 2); end
            4: begin r = $urandom_range(0, 20); g = $urandom_range(0, 20); b = $urandom_range(0, 20); end
            default: begin r = $urandom_range(0, 65535); g = $urandom_range(0, 65535); b = $urandom_range(0, 65535); end
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, g, b, kind, reps;
        model_reset();
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // red object, then a persisting red window
        repeat (4) send_window(1000, 200, 200, 1'b0, 1'b0);

        // dark and ambiguous windows
        send_window(5, 5, 5, 1'b0, 1'b0);
        send_window(1000, 900, 100, 1'b0, 1'b0);

        // averaging truncates 1001/4 -> 250
        drive_sample(100, 900, 100);
        drive_sample(200, 900, 100);
        drive_sample(300, 900, 100);
        drive_sample(401, 900, 100);
        window_done(1'b0, 1'b0);

        // margin and darkness boundaries
        send_window(1250, 1000, 0, 1'b0, 1'b0);
        send_window(1251, 1000, 0, 1'b0, 1'b0);
        send_window(63, 0, 0, 1'b0, 1'b0);
        send_window(64, 0, 0, 1'b0, 1'b0);
        send_window(65535, 65535, 65535, 1'b0, 1'b0);
        send_window(0, 0, 65535, 1'b0, 1'b0);

        // idle clear
        @(negedge clk); clear_counts = 1'b1;
        @(negedge clk); clear_counts = 1'b0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        check_counts("idle_clear");

        // debounce: R,R,G,R,R,R after settling on NONE
        repeat (3) send_window(5, 5, 5, 1'b0, 1'b0);
        send_window(1000, 200, 200, 1'b0, 1'b0);
        send_window(1000, 200, 200, 1'b0, 1'b0);
        send_window(200, 1000, 200, 1'b0, 1'b0);
        repeat (3) send_window(1000, 200, 200, 1'b0, 1'b0);
        repeat (3) send_window(5, 5, 5, 1'b0, 1'b0);
        repeat (3) send_window(1000, 200, 200, 1'b0, 1'b0);

        // five blue objects saturate the counter
        repeat (5) begin
            repeat (3) send_window(100, 100, 1000, 1'b0, 1'b0);
            repeat (3) send_window(5, 5, 5, 1'b0, 1'b0);
        end
        // clear coincident with an increment
        send_window(100, 100, 1000, 1'b0, 1'b0);
        send_window(100, 100, 1000, 1'b0, 1'b0);
        send_window(100, 100, 1000, 1'b0, 1'b1);

        // dropped sample in CALC, next window still needs four samples
        send_window(1000, 200, 200, 1'b1, 1'b0);
        send_window(200, 1000, 200, 1'b0, 1'b0);

        // reset in the middle of a window
        drive_sample(1000, 200, 200);
        drive_sample(1000, 200, 200);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        send_window(200, 200, 1000, 1'b0, 1'b0);

        // randomised objects
        repeat (30) begin
            kind = $urandom_range(0, 4);
            reps = $urandom_range(1, 4);
            repeat (reps) begin
                for (int i = 0; i < NSMP; i++) begin
                    random_triple(kind, r, g, b);
                    drive_sample(r, g, b);
                end
                window_done(($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/color_classifier.md
Name: color_classifier

Overview:
- Downstream consumer of the TCS34725 read FSM. Takes each completed red/green/blue 16-bit triple (qualified by the controller's one-cycle ready pulse) and averages 2^AVG_LOG2 triples.
- Classifies each average as NONE/RED/GREEN/BLUE using dominance comparisons, with no dividers.
- Debounces the class over STABLE_N consecutive windows.
- Keeps per-colour object counts for the SmartCount display/UART stages.

Parameters:
- AVG_LOG2, 2, log2 of the number of samples averaged per window (window = 4 samples).
- DARK_TH, 64, minimum avg_r+avg_g+avg_b for any colour decision; below it the class is NONE.
- MARGIN_SHIFT, 2, dominance margin: a channel dominates another iff ch > other + (other >> MARGIN_SHIFT), i.e. 25%.
- STABLE_N, 3, consecutive identical window classes required to change stable_class.
- CNT_W, 8, width of each per-colour counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- sample_valid  in  1  one-cycle pulse; red/green/blue are valid in that cycle
- red  in  16  clear-compensated red count
- green  in  16  green count
- blue  in  16  blue count
- clear_counts  in  1  synchronous clear of cnt_*
- class_valid  out  1  one-cycle pulse; color_class is updated
- color_class  out  2  last window class: 0 NONE, 1 RED, 2 GREEN, 3 BLUE
- stable_class  out  2  debounced class, same encoding
- count_pulse  out  1  one-cycle pulse when a cnt_* increments
- cnt_red  out  CNT_W  confirmed red objects
- cnt_green  out  CNT_W  confirmed green objects
- cnt_blue  out  CNT_W  confirmed blue objects
- overrun  out  1  one-cycle pulse; a sample arrived outside ACCUM and was dropped

Behaviour:
- Reset (async, any state): state=ACCUM; accumulators, sample counter, run_len, candidate, all outputs = 0 (classes = NONE).
- FSM states: ACCUM -> CALC -> UPDATE -> ACCUM.
- ACCUM:
  - On sample_valid, add each channel into a (16+AVG_LOG2)-bit accumulator and increment the sample counter.
  - On the 2^AVG_LOG2-th accepted sample, go to CALC.
- CALC (1 cycle):
  - avg_x = acc_x >> AVG_LOG2 (truncating).
  - Accumulators and sample counter cleared.
  - Register the window class:
    - total = 18-bit sum of the averages. total < DARK_TH -> NONE.
    - Else RED if red dominates both green and blue; else GREEN if green dominates red and blue; else BLUE if blue dominates red and green; else NONE.
    - Dominance compares in 17 bits with no overflow. At most one channel can dominate.
  - color_class is loaded at the CALC->UPDATE edge.
  - Go to UPDATE.
- UPDATE (1 cycle):
  - class_valid=1 for exactly this cycle. It is high two cycles after the cycle of the last accepted sample.
  - Run-length tracking:
    - If color_class == candidate: run_len = min(run_len+1, STABLE_N).
    - Otherwise: candidate = color_class and run_len = 1.
  - Confirm: if the updated run_len == STABLE_N and candidate != stable_class, stable_class <= candidate in the same cycle.
  - If that new stable class is not NONE, the matching cnt_* increments and count_pulse=1 in the next cycle, together with the new stable_class.
  - Go to ACCUM.
- Counting rule: every confirmed transition into RED/GREEN/BLUE (from NONE or from another colour) counts exactly once. The stable class persisting does not recount.
- Counters saturate at 2^CNT_W-1. At saturation count_pulse still pulses and the value holds.
- clear_counts zeroes all cnt_* next cycle; simultaneous with an increment, clear wins.
- It does not affect stable_class, candidate or averaging.
- Dropped samples: sample_valid in CALC or UPDATE is dropped, with overrun pulsed one cycle later. The upstream sample period (several I2C transactions) makes this a fault indicator only.
- Inputs are sampled only in the sample_valid cycle; changes at other times are ignored.

Decomposition:
- Shared package/header color_pkg:
  - class encodings CLS_NONE/CLS_RED/CLS_GREEN/CLS_BLUE.
  - FSM state localparams.
- One sub-module: color_dominance, combinational.
  - Inputs: three averages, DARK_TH, MARGIN_SHIFT.
  - Output: the 2-bit class.
  - Instantiated once and registered in CALC. Also reusable for the calibration bench.
- Everything else stays in color_classifier.

Test Plan:
- Red object: 3 windows of 4x (1000,200,200).
  - Each window: class_valid 2 cycles after the 4th sample, color_class=RED.
  - After window 3: stable_class=RED, cnt_red=1, one count_pulse.
  - A 4th RED window: no further count.
- Dark and ambiguous:
  - 4x (5,5,5) (total 15 < 64) -> NONE.
  - 4x (1000,900,100): 1000 is not > 900+225 -> NONE.
  - No counts in either case.
- Averaging: samples (100,…),(200,…),(300,…),(401,…) with 900/100 elsewhere.
  - avg_r=250 (1001>>2); green window dominant -> GREEN.
- Debounce: window classes RED,RED,GREEN,RED,RED,RED.
  - Only the final window confirms; cnt_red=1.
  - Then NONE x3 followed by RED x3 -> cnt_red=2.
- Saturation/clear:
  - CNT_W=2: 5 confirmed blue objects -> cnt_blue=3, 5 count_pulses.
  - clear_counts in the same cycle as an increment -> cnt_blue=0.
- Overrun/reset:
  - sample_valid on the CALC cycle -> overrun pulse; the next window still needs 4 fresh samples.
  - rst asserted after 2 samples -> all outputs 0 immediately; the next window needs 4 samples.
